// File: rtl/pgt_source_mux.sv
// pgt_source_mux: registered 2:1 selector driving the encoder pulse/tick
// line. Selects the counter path (cont) or the divider path (div) by sel,
// with every input synchronized first and an optional forced-low window
// on source changes so no partial pulse reaches pgt.
module pgt_source_mux #(
    parameter int unsigned SYNC_STAGES = 2,   // 0..3
    parameter bit          GLITCH_FREE = 1'b1,
    parameter int unsigned HOLD_CYCLES = 2    // 1..15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cont,
    input  logic div,
    input  logic sel,
    output logic pgt,
    output logic active_sel,
    output logic busy
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    logic cont_s;
    logic div_s;
    logic sel_s;

    // Synchronizer chain, one lane per input packed as {cont, div, sel}.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign {cont_s, div_s, sel_s} = {cont, div, sel};
        end else if (SYNC_STAGES == 1) begin : g_sync1
            logic [2:0] sq;
            // Single sampling stage for all three inputs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sq <= '0;
                end else begin
                    sq <= {cont, div, sel};
                end
            end
            assign {cont_s, div_s, sel_s} = sq;
        end else begin : g_syncn
            logic [3*SYNC_STAGES-1:0] sq;
            // Multi-stage shift: newest sample enters at the bottom,
            // oldest (fully synchronized) sample leaves at the top.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sq <= '0;
                end else begin
                    sq <= {sq[3*SYNC_STAGES-4:0], cont, div, sel};
                end
            end
            assign {cont_s, div_s, sel_s} = sq[3*SYNC_STAGES-1 -: 3];
        end
    endgenerate

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pgt_q, pgt_d;
    logic       act_q, act_d;

    // State, hold counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pgt_q   <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pgt_q   <= pgt_d;
            act_q   <= act_d;
        end
    end

    // Next-state logic: steady-state selection, switchover hold and abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        pgt_d   = 1'b0;
        if (!GLITCH_FREE) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            act_d   = sel_s;
            pgt_d   = sel_s ? div_s : cont_s;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (sel_s != act_q) begin
                        state_d = ST_HOLD;
                        cnt_d   = 4'(HOLD_CYCLES);
                    end else begin
                        pgt_d = act_q ? div_s : cont_s;
                    end
                end
                ST_HOLD: begin
                    // pgt stays low on every edge taken from the hold state;
                    // the selected source reappears one edge after exit.
                    if (sel_s == act_q) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        act_d   = sel_s;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign pgt        = pgt_q;
    assign active_sel = act_q;
    assign busy       = (state_q == ST_HOLD);

endmodule

// File: tb/tb_pgt_source_mux.sv
// Testbench for pgt_source_mux: three instances share one stimulus set.
//   dut_a: SYNC_STAGES=2, GLITCH_FREE=0
//   dut_b: SYNC_STAGES=2, GLITCH_FREE=1, HOLD_CYCLES=2
//   dut_c: SYNC_STAGES=0, GLITCH_FREE=1, HOLD_CYCLES=2
module tb_pgt_source_mux;

    logic clk;
    logic rst_n;
    logic cont;
    logic div;
    logic sel;

    logic pgt_a, act_a, busy_a;
    logic pgt_b, act_b, busy_b;
    logic pgt_c, act_c, busy_c;

    int checks;
    int failures;

    pgt_source_mux #(.SYNC_STAGES(2), .GLITCH_FREE(1'b0), .HOLD_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .cont(cont), .div(div), .sel(sel),
        .pgt(pgt_a), .active_sel(act_a), .busy(busy_a)
    );

    pgt_source_mux #(.SYNC_STAGES(2), .GLITCH_FREE(1'b1), .HOLD_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .cont(cont), .div(div), .sel(sel),
        .pgt(pgt_b), .active_sel(act_b), .busy(busy_b)
    );

    pgt_source_mux #(.SYNC_STAGES(0), .GLITCH_FREE(1'b1), .HOLD_CYCLES(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .cont(cont), .div(div), .sel(sel),
        .pgt(pgt_c), .active_sel(act_c), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic c;
        logic d;
        logic s;
        logic e;
    } vec_t;

    vec_t tv [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    initial begin
        logic [6:0] g_pgt, g_busy, g_act;
        logic [5:0] a_pgt, a_busy;

        checks   = 0;
        failures = 0;

        tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tv[2] = '{1'b1, 1'b0, 1'b0, 1'b1};
        tv[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tv[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        tv[5] = '{1'b0, 1'b1, 1'b1, 1'b1};
        tv[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tv[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state
        rst_n = 1'b0;
        cont  = 1'b0;
        div   = 1'b0;
        sel   = 1'b0;
        #2;
        check("reset_pgt_a", pgt_a, 1'b0);
        check("reset_pgt_b", pgt_b, 1'b0);
        check("reset_act_b", act_b, 1'b0);
        check("reset_busy_b", busy_b, 1'b0);
        check("reset_pgt_c", pgt_c, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();

        // Truth-table sweep
        for (int i = 0; i < 8; i++) begin
            cont = tv[i].c;
            div  = tv[i].d;
            sel  = tv[i].s;
            repeat (10) tick();
            check($sformatf("tt_pgt_a_%0d", i), pgt_a, tv[i].e);
            check($sformatf("tt_act_a_%0d", i), act_a, tv[i].s);
            check($sformatf("tt_pgt_b_%0d", i), pgt_b, tv[i].e);
            check($sformatf("tt_act_b_%0d", i), act_b, tv[i].s);
            check($sformatf("tt_busy_b_%0d", i), busy_b, 1'b0);
        end

        // Latency: cont 0->1 with sel=0
        cont = 1'b0;
        div  = 1'b0;
        sel  = 1'b0;
        repeat (10) tick();
        cont = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("lat_pgt_b_k%0d", k), pgt_b, (k >= 3) ? 1'b1 : 1'b0);
            check($sformatf("lat_pgt_c_k%0d", k), pgt_c, 1'b1);
        end

        // Glitch-free switch cont -> div, both sources high
        div = 1'b1;
        repeat (5) tick();
        g_pgt  = 7'b1100011;
        g_busy = 7'b0001100;
        g_act  = 7'b1110000;
        sel = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("sw_pgt_k%0d", k + 1), pgt_b, g_pgt[k]);
            check($sformatf("sw_busy_k%0d", k + 1), busy_b, g_busy[k]);
            check($sformatf("sw_act_k%0d", k + 1), act_b, g_act[k]);
        end

        // Abort: one-clock sel pulse during steady sel=0, cont=1
        sel = 1'b0;
        div = 1'b0;
        repeat (10) tick();
        check("abort_pre_pgt", pgt_b, 1'b1);
        a_busy = 6'b000100;
        a_pgt  = 6'b110011;
        sel = 1'b1;
        tick();
        check("abort_k1_busy", busy_b, 1'b0);
        check("abort_k1_pgt", pgt_b, 1'b1);
        sel = 1'b0;
        for (int k = 1; k < 6; k++) begin
            tick();
            check($sformatf("abort_busy_k%0d", k + 1), busy_b, a_busy[k]);
            check($sformatf("abort_pgt_k%0d", k + 1), pgt_b, a_pgt[k]);
            check($sformatf("abort_act_k%0d", k + 1), act_b, 1'b0);
        end

        // Asynchronous reset in the middle of a hold
        sel = 1'b1;
        repeat (4) tick();
        check("rst_pre_busy", busy_b, 1'b1);
        check("rst_pre_pgt", pgt_b, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_pgt", pgt_b, 1'b0);
        check("rst_async_busy", busy_b, 1'b0);
        check("rst_async_act", act_b, 1'b0);
        check("rst_async_act_c", act_c, 1'b0);
        sel  = 1'b0;
        cont = 1'b1;
        #2;
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("rst_rel_pgt_b_k%0d", k), pgt_b, (k >= 3) ? 1'b1 : 1'b0);
            check($sformatf("rst_rel_pgt_c_k%0d", k), pgt_c, 1'b1);
        end
        check("rst_rel_busy_b", busy_b, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pgt_source_mux.md
Name: pgt_source_mux

Overview:
- Registered 2:1 selector that drives the pulse/tick line `pgt` of the microwave BCD encoder.
- Chooses between the counter-derived signal `cont` and the divider-derived signal `div`, using `sel`.
- Inputs may be asynchronous to `clk`, so each is synchronized first.
- On a change of source, the output is held low for a defined window so no partial or glitch pulse reaches `pgt`.

Parameters:
- SYNC_STAGES, default 2: synchronizer depth on `cont`, `div` and `sel`. Legal values 0..3; 0 means inputs are sampled directly by the first register.
- GLITCH_FREE, default 1: 1 means a source change forces `pgt` low for HOLD_CYCLES; 0 means the switch is immediate.
- HOLD_CYCLES, default 2: length of the forced-low window during a switchover. Legal values 1..15.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- cont, input, 1: counter-path source, selected when `sel`=0.
- div, input, 1: divider-path source, selected when `sel`=1.
- sel, input, 1: source select.
- pgt, output, 1: registered selected output.
- active_sel, output, 1: the source currently driving `pgt`.
- busy, output, 1: high while a switchover hold is in progress.

Behaviour:
- Reset (rst_n=0, asynchronous): all synchronizer flops, `pgt`, `active_sel`, `busy` and the hold counter go to 0 immediately. Reset release is sampled on the next clock edge.
- Synchronization: `cont`, `div` and `sel` each pass through SYNC_STAGES flops, giving `cont_s`, `div_s` and `sel_s`.
- Steady state (busy=0, sel_s=active_sel): `pgt` next = active_sel ? div_s : cont_s.
  - Truth table: sel 0 gives pgt=cont; sel 1 gives pgt=div. The other data input is don't-care.
- Latency: a data input change appears on `pgt` exactly SYNC_STAGES+1 clocks later.
- Switchover with GLITCH_FREE=1:
  - On the cycle sel_s differs from active_sel with busy=0: busy goes to 1, `pgt` goes to 0, and the counter loads HOLD_CYCLES.
  - While busy: `pgt` stays 0 and the counter decrements each cycle.
  - When the counter reaches 0: `active_sel` takes sel_s and busy goes to 0. On the next cycle `pgt` follows the new source.
- Abort: if sel_s returns to `active_sel` during the hold, busy clears on the next cycle, the counter clears, and `pgt` resumes the old source. `active_sel` never changes in this case.
- Switchover with GLITCH_FREE=0: `active_sel` takes sel_s on the same edge it is first seen, busy stays 0, and `pgt` follows the new source with no forced-low cycles.
- Simultaneous changes: data inputs changing together with `sel` are handled by the rules above; they need no special priority.
- Reset mid-switchover: the hold is abandoned and `active_sel` returns to 0.
- No combinational path from any input to any output.

Test Plan:
- Truth-table sweep (SYNC_STAGES=2, GLITCH_FREE=0): step (cont,div,sel) through 000, 010, 100, 110, 001, 011, 101, 111, 10 clocks each. After settling, `pgt` must read 0,0,1,1,0,1,0,1.
- Latency: with sel=0 held, toggle `cont` 0→1. `pgt` must rise exactly 3 clocks later (SYNC_STAGES=2); change to 1 clock with SYNC_STAGES=0.
- Glitch-free switch (GLITCH_FREE=1, HOLD_CYCLES=2): hold cont=1, div=1, sel=0, then set sel=1. Required sequence:
  - `pgt` low and busy high for the hold window;
  - `active_sel` becomes 1 once the hold counter reaches 0, with busy dropping to 0 on that same edge;
  - `pgt` returns to 1 on the following clock.
- Abort: pulse `sel` high for 1 clock during steady state sel=0, cont=1. busy must assert then clear, `active_sel` must stay 0, and `pgt` must return to 1 with no switch.
- Reset: assert rst_n=0 asynchronously mid-hold. `pgt`, `busy` and `active_sel` must go to 0 without a clock edge. After release with sel=0 and cont=1, `pgt` must be 1 after SYNC_STAGES+1 clocks.
